// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the PC generator and its neighbours
// (hazard control, BTB, execute-stage redirect and instruction memory).
interface pc_gen_if #(
    parameter int ADDR_W = 64
) ();
    logic              hold_i;
    logic              jmp_prediction_i;
    logic [ADDR_W-1:0] target_pc_pred_i;
    logic              prediction_error_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              if_ready_i;
    logic [ADDR_W-1:0] pc_o;
    logic              if_req_o;
    logic              fetch_kill_o;
    logic              flush_o;
    logic [31:0]       redirect_cnt_o;

    // PC generator side
    modport slave (
        input  hold_i, jmp_prediction_i, target_pc_pred_i,
        input  prediction_error_i, redirect_pc_i, if_ready_i,
        output pc_o, if_req_o, fetch_kill_o, flush_o, redirect_cnt_o
    );

    // Environment side (pipeline control, BTB, memory)
    modport master (
        output hold_i, jmp_prediction_i, target_pc_pred_i,
        output prediction_error_i, redirect_pc_i, if_ready_i,
        input  pc_o, if_req_o, fetch_kill_o, flush_o, redirect_cnt_o
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: sequential/predicted next-PC selection,
// fetch request handshake with stall tracking and misprediction redirect,
// including a redirect that arrives while a fetch is still outstanding.
module pc_gen #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BOOT_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic   clk,
    input  logic   rst_n,
    pc_gen_if.slave bus
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_PEND = 2'd3;

    // Clears the two byte-offset bits so every fetch address is word aligned
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [31:0]       CNT_MAX    = 32'hFFFF_FFFF;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [31:0]       cnt_q, cnt_d;

    logic              req;
    logic              kill;
    logic              flush;
    logic              accept;
    logic              err;
    logic [ADDR_W-1:0] redir_al;
    logic [ADDR_W-1:0] next_seq;

    assign err      = bus.prediction_error_i;
    assign redir_al = bus.redirect_pc_i & ALIGN_MASK;
    // Next PC when no redirect applies: BTB target if predicted taken, else fall-through
    assign next_seq = bus.jmp_prediction_i ? (bus.target_pc_pred_i & ALIGN_MASK)
                                           : (pc_q + ADDR_W'(4));

    // Request/flush outputs and accept qualification per state
    always_comb begin
        req   = 1'b0;
        flush = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                req   = !bus.hold_i && !err;
                flush = err;
            end
            ST_WAIT, ST_PEND: begin
                req   = 1'b1;
                flush = err;
            end
            default: begin
                req   = 1'b0;
                flush = 1'b0;
            end
        endcase
        accept = req && bus.if_ready_i;
    end

    // FSM next state, PC and pending-redirect selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        kill    = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (err) begin
                    // Redirect wins over hold; no request goes out this cycle
                    pc_d = redir_al;
                end else if (bus.hold_i) begin
                    pc_d = pc_q;
                end else if (accept) begin
                    pc_d = next_seq;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (err) begin
                    if (bus.if_ready_i) begin
                        // The fetch being accepted now is wrong-path
                        pc_d    = redir_al;
                        kill    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        // Keep the request stable; apply redirect once memory accepts
                        pend_d  = redir_al;
                        state_d = ST_PEND;
                    end
                end else if (bus.if_ready_i) begin
                    pc_d    = next_seq;
                    state_d = ST_RUN;
                end
            end
            default: begin
                // ST_PEND: outstanding wrong-path request, redirect already known
                if (bus.if_ready_i) begin
                    pc_d    = err ? redir_al : pend_q;
                    kill    = 1'b1;
                    state_d = ST_RUN;
                end else if (err) begin
                    pend_d = redir_al;
                end
            end
        endcase
    end

    // Saturating misprediction counter, frozen during boot
    always_comb begin
        cnt_d = cnt_q;
        if (err && (state_q != ST_BOOT) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // State registers; asynchronous reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= BOOT_ADDR;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_o           = pc_q;
    assign bus.if_req_o       = req;
    assign bus.fetch_kill_o   = kill;
    assign bus.flush_o        = flush;
    assign bus.redirect_cnt_o = cnt_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, fetch/PC address width.
REQ-002 SHALL have parameter BOOT_ADDR, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port hold_i  input  1  pipeline stall from hazard control.
REQ-006 SHALL have port jmp_prediction_i  input  1  BTB taken prediction for pc_o.
REQ-007 SHALL have port target_pc_pred_i  input  ADDR_W  BTB predicted target for pc_o.
REQ-008 SHALL have port prediction_error_i  input  1  execute-stage misprediction strobe.
REQ-009 SHALL have port redirect_pc_i  input  ADDR_W  correct next PC, valid with prediction_error_i.
REQ-010 SHALL have port if_ready_i  input  1  instruction memory accepts request.
REQ-011 SHALL have port pc_o  output  ADDR_W  current fetch PC, also drives BTB lookup.
REQ-012 SHALL have port if_req_o  output  1  fetch request valid.
REQ-013 SHALL have port fetch_kill_o  output  1  accepted fetch this cycle is wrong-path, discard.
REQ-014 SHALL have port flush_o  output  1  kill younger instructions in IF/ID.
REQ-015 SHALL have port redirect_cnt_o  output  32  misprediction count.

Function
REQ-016 SHALL implement states BOOT, RUN, WAIT, PEND; pc_o always equals internal pc register.
REQ-017 SHALL go BOOT->RUN unconditionally one cycle after reset release; if_req_o=0, flush_o=0, counter frozen in BOOT.
REQ-018 SHALL drive if_req_o = !hold_i && !prediction_error_i in RUN, and 1 in WAIT and PEND.
REQ-019 SHALL define accept as if_req_o && if_ready_i; next PC on accept without redirect = {target_pc_pred_i[ADDR_W-1:2],2'b00} if jmp_prediction_i else pc+4 modulo 2^ADDR_W.
REQ-020 RUN: hold_i=1 without error -> pc holds, stay RUN; accept -> pc=next PC, stay RUN; if_req_o=1 and !if_ready_i -> WAIT, pc holds.
REQ-021 RUN with prediction_error_i=1 (hold_i ignored) -> pc={redirect_pc_i[ADDR_W-1:2],2'b00} next cycle, no request issued that cycle, stay RUN.
REQ-022 WAIT: pc and if_req_o stable until accept, regardless of hold_i; accept without error -> pc=next PC, RUN.
REQ-023 WAIT with error and if_ready_i=1 -> pc=aligned redirect_pc_i, fetch_kill_o=1, RUN.
REQ-024 WAIT with error and if_ready_i=0 -> latch aligned redirect_pc_i into pending register, PEND, pc unchanged.
REQ-025 PEND: accept -> pc=pending register, fetch_kill_o=1, RUN; another error before accept overwrites pending register (latest wins); same-cycle error and accept uses redirect_pc_i.
REQ-026 SHALL drive flush_o = prediction_error_i combinationally in RUN, WAIT, PEND.
REQ-027 SHALL assert fetch_kill_o only in the accept cycles of REQ-023/REQ-025, else 0.
REQ-028 SHALL increment redirect_cnt_o by 1 each cycle prediction_error_i=1 outside BOOT, saturating at 32'hFFFF_FFFF.
REQ-029 SHALL ignore jmp_prediction_i/target_pc_pred_i whenever a redirect applies.

Reset
REQ-030 On rst_n=0, asynchronously: state=BOOT, pc_o=BOOT_ADDR, pending register=0, redirect_cnt_o=0; if_req_o, fetch_kill_o, flush_o=0.
REQ-031 Reset mid-WAIT/PEND SHALL abandon the outstanding request and pending redirect without further outputs.

Verification
REQ-032 Reset release, if_ready_i=1, no prediction -> if_req_o rises cycle 2, pc_o 0x80000000, 0x80000004, 0x80000008.
REQ-033 pc_o=0x80000010, jmp_prediction_i=1, target 0x80000102, accept -> pc_o=0x80000100.
REQ-034 if_ready_i=0 two cycles in WAIT with hold_i toggling -> pc_o, if_req_o unchanged; accept third cycle -> pc+4.
REQ-035 WAIT, error with redirect 0x80000200, if_ready_i=0 -> PEND, flush_o=1 one cycle; accept later -> fetch_kill_o=1, pc_o=0x80000200.
REQ-036 RUN, hold_i=1 and error with redirect 0x80000300 -> if_req_o=0, flush_o=1, next pc_o=0x80000300, redirect_cnt_o=1.
REQ-037 Preload counter to 32'hFFFF_FFFE, three errors -> redirect_cnt_o ends 32'hFFFF_FFFF.
